// File: rtl/pkt_framer_if.sv
// Payload-in / packet-out bundle for pkt_framer.
// The slave modport is the framer side; the master modport is the side that feeds it and watches its output.
interface pkt_framer_if #(
    parameter int BUS_SIZE  = 60,
    parameter int WORD_SIZE = 6
);
    localparam int PAY_SIZE = BUS_SIZE - 2 * WORD_SIZE;

    logic [PAY_SIZE-1:0] pay_in;
    logic                pay_valid;
    logic                pay_ready;
    logic                new_frame;
    logic                out_stall;
    logic [BUS_SIZE-1:0] data_out;
    logic                data_valid;

    modport slave (
        input  pay_in,
        input  pay_valid,
        input  new_frame,
        input  out_stall,
        output pay_ready,
        output data_out,
        output data_valid
    );

    modport master (
        output pay_in,
        output pay_valid,
        output new_frame,
        output out_stall,
        input  pay_ready,
        input  data_out,
        input  data_valid
    );
endinterface

// File: rtl/pkt_framer.sv
// Packet framer: wraps buffered payload as {all-ones header, payload, sequence number}
// and drives an all-zero idle word whenever no packet goes out.
//
//  state    | meaning
//  S_RESET  | held in reset, or the first cycle after reset is released; nothing is emitted
//  S_IDLE   | the last output was the idle word; the next packet starts a frame at seq 0
//  S_STREAM | the last output was a packet; the next packet continues the frame
module pkt_framer #(
    parameter int BUS_SIZE  = 60,
    parameter int WORD_SIZE = 6,
    parameter int FRAME_LEN = 2 ** WORD_SIZE
) (
    input  logic         clk,
    input  logic         reset,
    pkt_framer_if.slave  bus
);
    localparam int PAY_SIZE = BUS_SIZE - 2 * WORD_SIZE;
    localparam logic [WORD_SIZE-1:0] SEQ_LAST = WORD_SIZE'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_RESET  = 3'b001,
        S_IDLE   = 3'b010,
        S_STREAM = 3'b100
    } state_t;

    state_t              state;
    logic [PAY_SIZE-1:0] mem [0:1];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;
    logic [1:0]          count_next;
    logic [WORD_SIZE-1:0] seq;
    logic [WORD_SIZE-1:0] seq_next;
    logic                frame_flag;
    logic                do_write;
    logic                do_read;
    logic                start_frame;

    assign do_write    = bus.pay_valid & bus.pay_ready;
    assign do_read     = (count != 2'd0) & ~bus.out_stall & (state != S_RESET);
    // A gap in the stream restarts the frame, so downstream never sees a sequence jump.
    assign start_frame = (state == S_IDLE) | frame_flag | bus.new_frame | (seq == SEQ_LAST);
    assign seq_next    = start_frame ? '0 : seq + WORD_SIZE'(1);

    always_comb begin
        count_next = count;
        if (do_write && !do_read)
            count_next = count + 2'd1;
        else if (!do_write && do_read)
            count_next = count - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr] <= bus.pay_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_RESET;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            count          <= 2'd0;
            seq            <= '0;
            frame_flag     <= 1'b0;
            bus.pay_ready  <= 1'b0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
        end else begin
            count         <= count_next;
            bus.pay_ready <= (count_next < 2'd2);
            if (do_write)
                wr_ptr <= ~wr_ptr;
            if (do_read) begin
                rd_ptr         <= ~rd_ptr;
                seq            <= seq_next;
                frame_flag     <= 1'b0;
                bus.data_out   <= {{WORD_SIZE{1'b1}}, mem[rd_ptr], seq_next};
                bus.data_valid <= 1'b1;
                state          <= S_STREAM;
            end else begin
                frame_flag     <= frame_flag | bus.new_frame;
                bus.data_out   <= '0;
                bus.data_valid <= 1'b0;
                state          <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_pkt_framer.sv
// Self-checking bench for pkt_framer: two instances (full 64-packet frame and a 4-packet frame)
// share one stimulus stream and are compared every cycle against a queue-based reference model.
module tb_pkt_framer;
    localparam int BUS  = 60;
    localparam int WORD = 6;
    localparam int PAY  = BUS - 2 * WORD;

    typedef logic [PAY-1:0] pay_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pkt_framer_if #(.BUS_SIZE(BUS), .WORD_SIZE(WORD)) bus_a ();
    pkt_framer_if #(.BUS_SIZE(BUS), .WORD_SIZE(WORD)) bus_b ();

    pkt_framer #(.BUS_SIZE(BUS), .WORD_SIZE(WORD)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    pkt_framer #(.BUS_SIZE(BUS), .WORD_SIZE(WORD), .FRAME_LEN(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: payload queue plus frame bookkeeping, one sequence tracker per frame length.
    pay_t mq[$];
    bit   m_ready  = 1'b0;
    bit   m_stream = 1'b0;
    bit   m_flag   = 1'b0;
    bit   m_rst    = 1'b1;
    int   m_seq_a  = 0;
    int   m_seq_b  = 0;

    task automatic step(input bit rst_v, input bit vld, input bit nf, input bit stl);
        pay_t           p;
        pay_t           head;
        bit             acc;
        bit             fresh;
        bit             ev;
        logic [BUS-1:0] ea;
        logic [BUS-1:0] eb;
        p = pay_t'({$urandom(), $urandom()});
        reset           = rst_v;
        bus_a.pay_in    = p;   bus_b.pay_in    = p;
        bus_a.pay_valid = vld; bus_b.pay_valid = vld;
        bus_a.new_frame = nf;  bus_b.new_frame = nf;
        bus_a.out_stall = stl; bus_b.out_stall = stl;

        ev = 1'b0; ea = '0; eb = '0;
        if (!rst_v) begin
            mq.delete();
            m_ready = 1'b0; m_stream = 1'b0; m_flag = 1'b0; m_rst = 1'b1;
            m_seq_a = 0; m_seq_b = 0;
        end else begin
            acc = vld && m_ready;
            if (mq.size() > 0 && !stl && !m_rst) begin
                head  = mq.pop_front();
                fresh = !m_stream || m_flag || nf;
                m_seq_a = (fresh || m_seq_a == 63) ? 0 : m_seq_a + 1;
                m_seq_b = (fresh || m_seq_b == 3)  ? 0 : m_seq_b + 1;
                ea = {6'h3F, head, 6'(m_seq_a)};
                eb = {6'h3F, head, 6'(m_seq_b)};
                ev = 1'b1; m_stream = 1'b1; m_flag = 1'b0;
            end else begin
                m_stream = 1'b0;
                m_flag   = m_flag || nf;
            end
            if (acc) mq.push_back(p);
            m_ready = (mq.size() < 2);
            m_rst   = 1'b0;
        end

        @(posedge clk);
        #1;
        checks++;
        assert (bus_a.data_out === ea) else begin
            errors++; $error("FAIL data_a got %h expected %h", bus_a.data_out, ea);
        end
        checks++;
        assert (bus_a.data_valid === ev) else begin
            errors++; $error("FAIL valid_a got %b expected %b", bus_a.data_valid, ev);
        end
        checks++;
        assert (bus_a.pay_ready === m_ready) else begin
            errors++; $error("FAIL ready_a got %b expected %b", bus_a.pay_ready, m_ready);
        end
        checks++;
        assert (bus_b.data_out === eb) else begin
            errors++; $error("FAIL data_b got %h expected %h", bus_b.data_out, eb);
        end
        checks++;
        assert (bus_b.data_valid === ev) else begin
            errors++; $error("FAIL valid_b got %b expected %b", bus_b.data_valid, ev);
        end
        checks++;
        assert (bus_b.pay_ready === m_ready) else begin
            errors++; $error("FAIL ready_b got %b expected %b", bus_b.pay_ready, m_ready);
        end
    endtask

    initial begin
        bus_a.pay_in = '0; bus_a.pay_valid = 1'b0; bus_a.new_frame = 1'b0; bus_a.out_stall = 1'b0;
        bus_b.pay_in = '0; bus_b.pay_valid = 1'b0; bus_b.new_frame = 1'b0; bus_b.out_stall = 1'b0;

        // reset, then back-to-back payloads
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

        // nine continuous payloads: short frame wraps 0..3
        repeat (9) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

        // single stall cycle mid-stream
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

        // new_frame pulse inside a running stream
        repeat (7) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

        // stall held three cycles with continuous valid, then release
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);

        // reset with two entries buffered
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

        // long stream: full-length frame wraps 63 -> 0
        repeat (72) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
